// File: rtl/bcd_to_bin_3_digits_seq_pkg.sv
// Shared constants, state encoding and operand helper for the
// three-digit BCD to binary converter.
package bcd_to_bin_3_digits_seq_pkg;

   localparam int NUM_DIGITS = 3;
   localparam int BIN_W      = 10;
   localparam int ITER       = 10;
   localparam int BCD_W      = NUM_DIGITS * 4;
   localparam int CNT_W      = $clog2(ITER);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // True when any 4-bit digit of the packed BCD operand exceeds 9.
   function automatic logic has_bad_digit(input logic [BCD_W-1:0] bcd);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

endpackage

// File: rtl/bcd_to_bin_3_digits_seq_if.sv
// Request/result bundle between a requester and the converter.
interface bcd_to_bin_3_digits_seq_if;
   import bcd_to_bin_3_digits_seq_pkg::*;

   logic             start;
   logic [3:0]       d0;
   logic [3:0]       d1;
   logic [3:0]       d2;
   logic             busy;
   logic             done;
   logic [BIN_W-1:0] bin;
   logic             error;

   modport master (
      output start, d0, d1, d2,
      input  busy, done, bin, error
   );

   modport slave (
      input  start, d0, d1, d2,
      output busy, done, bin, error
   );

endinterface

// File: rtl/bcd_to_bin_3_digits_seq_bcd_digit_correct.sv
// Per-digit correction step of the reverse double-dabble: a digit that
// reads 8 or more after the right shift has 3 taken off (never underflows).
module bcd_digit_correct (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   // Subtract 3 from digits of 8 or more, pass smaller digits through.
   always_comb begin
      dout = din;
      if (din >= 4'd8) dout = din - 4'd3;
   end

endmodule

// File: rtl/bcd_to_bin_3_digits_seq.sv
// Sequential three-digit BCD to binary converter. The operand is shifted
// right one bit per cycle through a {bcd, bin} register for ITER cycles,
// with each BCD digit corrected after every shift. Out-of-range digits
// short-circuit straight to DONE with error set.
module bcd_to_bin_3_digits_seq
   import bcd_to_bin_3_digits_seq_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   bcd_to_bin_3_digits_seq_if.slave bus
);

   state_t                   state;
   state_t                   state_nxt;
   logic [BCD_W-1:0]         bcd_q;
   logic [BIN_W-1:0]         acc_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [BIN_W-1:0]         bin_q;
   logic                     err_q;

   logic [BCD_W-1:0]         operand;
   logic                     op_bad;
   logic                     last_iter;
   logic [BCD_W+BIN_W-1:0]   shifted;
   logic [BCD_W-1:0]         bcd_fix;
   logic [BIN_W-1:0]         acc_nxt;

   assign operand   = {bus.d2, bus.d1, bus.d0};
   assign op_bad    = has_bad_digit(operand);
   assign last_iter = (cnt_q == LAST_ITER);

   // The BCD LSB falls into the binary MSB on each shift.
   assign shifted = {bcd_q, acc_q} >> 1;
   assign acc_nxt = shifted[BIN_W-1:0];

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit_correct u_fix (
         .din  (shifted[BIN_W + 4*g +: 4]),
         .dout (bcd_fix[4*g +: 4])
      );
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; start is only honoured in IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = op_bad ? DONE : SHIFT;
         SHIFT:   if (last_iter) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Shift register, iteration counter and result registers; results
   // change only on the edge that enters DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_q <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         bin_q <= '0;
         err_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  bcd_q <= operand;
                  acc_q <= '0;
                  cnt_q <= '0;
                  if (op_bad) begin
                     bin_q <= '0;
                     err_q <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               bcd_q <= bcd_fix;
               acc_q <= acc_nxt;
               cnt_q <= cnt_q + 1'b1;
               if (last_iter) begin
                  bin_q <= acc_nxt;
                  err_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy  = (state != IDLE);
   assign bus.done  = (state == DONE);
   assign bus.bin   = bin_q;
   assign bus.error = err_q;

endmodule

// File: doc/bcd_to_bin_3_digits_seq.md
BCD_TO_BIN_3_DIGITS_SEQ -- requirements
Module: bcd_to_bin_3_digits_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to convert; acted on only in IDLE.
REQ-005 d0  input  4  BCD units digit.
REQ-006 d1  input  4  BCD tens digit.
REQ-007 d2  input  4  BCD hundreds digit.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse marking a valid result or error.
REQ-010 bin  output  10  binary value of d2*100 + d1*10 + d0 (0..999).
REQ-011 error  output  1  high when the last accepted operand held a digit greater than 9.

Function
REQ-012 States SHALL be IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, the block SHALL latch d2,d1,d0 into a 12-bit BCD field and clear a 10-bit binary field and iteration counter.
- If every digit is 9 or less, it SHALL go to SHIFT.
- If any digit is greater than 9, it SHALL go to DONE with error=1 and bin=0.
REQ-014 In SHIFT, one iteration per cycle SHALL shift the 22-bit {bcd,bin} register right by 1.
- The BCD LSB enters the bin MSB.
- Each 4-bit BCD digit of 8 or more SHALL then have 3 subtracted, in the same cycle.
REQ-015 SHIFT SHALL last exactly 10 cycles, counter 0..9, and then go to DONE.
- After the last iteration the BCD field SHALL be zero.
REQ-016 In DONE, done SHALL be 1 for exactly one cycle, and the state SHALL return to IDLE.
REQ-017 bin and error SHALL update only on entry to DONE, and SHALL hold until the next DONE or reset.
REQ-018 Latency: start is sampled at edge N.
- Valid operand: done=1 in the cycle after edge N+10.
- Invalid operand: done=1 in the cycle after edge N.
REQ-019 start SHALL be ignored in SHIFT and DONE; it is not queued, and latched digits SHALL NOT change.
REQ-020 start held high continuously SHALL start a new conversion on the first IDLE cycle after DONE.
REQ-021 error SHALL be cleared on a valid conversion's DONE.
REQ-022 All arithmetic SHALL be unsigned, and digit correction SHALL never underflow, since a digit of 8 or more minus 3 is 5 or more.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, bin=0, error=0, counter=0 and a cleared shift register.
REQ-024 Reset during SHIFT SHALL abort the conversion with no done pulse; after release, the block SHALL accept start in the first cycle.

Structure
REQ-025 A shared package SHALL hold NUM_DIGITS=3, BIN_W=10, ITER=10 and the state encoding.
REQ-026 One sub-module, bcd_digit_correct, SHALL be used.
- It is a 4-bit combinational block: if the input is 8 or more, output = input - 3; otherwise output = input.
- It is instantiated once per digit.
REQ-027 The FSM, counter and shift register SHALL live in the top module; there SHALL be no other sub-modules.

Verification
REQ-028 d2,d1,d0=9,9,9, start pulse -> busy 10 cycles, then done=1 with bin=999 (0x3E7) and error=0.
REQ-029 Operands 0,0,0 -> bin=0; 1,0,0 -> bin=100; 1,2,3 -> bin=123; each with done exactly 11 cycles after the start edge.
REQ-030 d1=0xA, start -> done the next cycle with error=1 and bin=0, no SHIFT cycles.
- A following valid conversion of 0,4,2 -> bin=42 and error=0.
REQ-031 Start 4,5,6, then start pulses with 7,7,7 during busy -> only bin=456 is produced, with a single done pulse.
REQ-032 rst_n low at SHIFT iteration 5 -> outputs zero at once and no done pulse.
- After release, start 0,1,0 -> bin=10.
REQ-033 start held high for 30 cycles with 3,2,1 -> done pulses 12 cycles apart, each with bin=321.
